id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline; sits between the IF/ID register and the ID/EX register.
- Holds the 32x32 register file and decodes the instruction into EX/MEM/WB control signals.
- Detects load-use and branch data hazards, and resolves beq/bne/j in ID.
- Drives every ID-side input of the ID/EX register, including its Flush.

---
 rtl/mips_pkg.sv | 86 ++++++++
 rtl/reg_file.sv | 57 +++++
 rtl/id_stage.sv | 153 +++++++++++++++
 tb/tb_id_stage.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and decode helper for the MIPS pipeline.
//   - opcode / funct constants for the supported instruction subset
//   - ALUOp and PCSrc encodings
//   - ctrl_t: the decoded EX/MEM/WB control bundle handed to ID/EX
//   - decode_ctrl(): opcode/funct -> ctrl_t (unsupported encodings give all-zero)
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_R: begin
                // Only the supported R-type functions produce control; the
                // rest of the R space is treated as a nop.
                if (funct == FUNCT_ADD || funct == FUNCT_SUB || funct == FUNCT_AND ||
                    funct == FUNCT_OR  || funct == FUNCT_SLT) begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = 1'b1;
                    c.alu_op    = ALUOP_FUNCT;
                end
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_ANDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_AND;
            end
            OP_BEQ, OP_BNE: begin
                c.alu_op = ALUOP_SUB;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: NREG x DW register file, one write port, two combinational read
// ports with write-through bypass. Register 0 reads zero and ignores writes.
//   clk, rst        : clock, asynchronous active-high reset (clears all regs)
//   we/waddr/wdata  : write port, committed on posedge clk
//   raddr1/rdata1   : read port 1
//   raddr2/rdata2   : read port 2
module reg_file
#(
    parameter int NREG = 32,
    parameter int DW   = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          wr_live;

    // A write seen while reset is held is dropped, so it must not bypass either.
    assign wr_live = we && !rst && (waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = (wr_live && waddr == raddr1) ? wdata : regs_q[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = (wr_live && waddr == raddr2) ? wdata : regs_q[raddr2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage between IF/ID and ID/EX.
//   Inputs : Instr/PCPlus4 from IF/ID; WB write port; EX and MEM stage
//            control/destination for hazard detection; MEMALUResult for
//            branch-operand forwarding.
//   Outputs: decoded control and operands for ID/EX, PC/IF-ID enables,
//            IDEXFlush bubble request, IFFlush, PCSrc and branch/jump targets.
// Decode, hazard detection and branch compare are all combinational; the only
// state is the register file.
module id_stage
    import mips_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [31:0]   Instr,
    input  logic [DW-1:0] PCPlus4,
    input  logic          WBRegWrite,
    input  logic [4:0]    WBWriteReg,
    input  logic [DW-1:0] WBWriteData,
    input  logic          EXRegWrite,
    input  logic          EXMemRead,
    input  logic [4:0]    EXWriteReg,
    input  logic          MEMRegWrite,
    input  logic          MEMMemRead,
    input  logic [4:0]    MEMWriteReg,
    input  logic [DW-1:0] MEMALUResult,
    output logic          IDRegWrite,
    output logic          IDMemtoReg,
    output logic          IDMemWrite,
    output logic          IDMemRead,
    output logic          IDRegDst,
    output logic          IDALUSrc,
    output logic [1:0]    IDALUOp,
    output logic [DW-1:0] IDRegData1,
    output logic [DW-1:0] IDRegData2,
    output logic [DW-1:0] IDSignExImm,
    output logic [4:0]    IDrs,
    output logic [4:0]    IDrt,
    output logic [4:0]    IDrd,
    output logic          PCWrite,
    output logic          IFIDWrite,
    output logic          IDEXFlush,
    output logic          IFFlush,
    output logic [1:0]    PCSrc,
    output logic [DW-1:0] BranchTarget,
    output logic [DW-1:0] JumpTarget
);

    logic [5:0]    opcode;
    logic [5:0]    funct;
    ctrl_t         ctrl;
    ctrl_t         ctrl_out;
    logic          is_beq, is_bne, is_branch, is_j, uses_rt;
    logic          ex_match, mem_match;
    logic          load_use, branch_stall, stall;
    logic          taken, jump;
    logic [DW-1:0] rd1, rd2, cmp_a, cmp_b;

    assign opcode = Instr[31:26];
    assign funct  = Instr[5:0];
    assign IDrs   = Instr[25:21];
    assign IDrt   = Instr[20:16];
    assign IDrd   = Instr[15:11];

    assign IDSignExImm  = {{(DW-16){Instr[15]}}, Instr[15:0]};
    assign BranchTarget = PCPlus4 + {IDSignExImm[DW-3:0], 2'b00};
    assign JumpTarget   = {PCPlus4[31:28], Instr[25:0], 2'b00};

    reg_file #(.NREG(NREG), .DW(DW)) u_reg_file (
        .clk    (Clk),
        .rst    (Reset),
        .we     (WBRegWrite),
        .waddr  (WBWriteReg),
        .wdata  (WBWriteData),
        .raddr1 (IDrs),
        .raddr2 (IDrt),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    assign IDRegData1 = rd1;
    assign IDRegData2 = rd2;

    always_comb begin
        ctrl      = decode_ctrl(opcode, funct);
        is_beq    = (opcode == OP_BEQ);
        is_bne    = (opcode == OP_BNE);
        is_branch = is_beq || is_bne;
        is_j      = (opcode == OP_J);
        // rt is a source for R-type, branches and sw; for lw/addi/andi it is
        // the destination and must not trigger a load-use stall.
        uses_rt   = (opcode == OP_R) || is_branch || (opcode == OP_SW);
    end

    always_comb begin
        ex_match  = (EXWriteReg != 5'd0) && (EXWriteReg == IDrs || EXWriteReg == IDrt);
        mem_match = (MEMWriteReg != 5'd0) && (MEMWriteReg == IDrs || MEMWriteReg == IDrt);

        load_use = EXMemRead && (EXWriteReg != 5'd0) &&
                   (EXWriteReg == IDrs || (uses_rt && EXWriteReg == IDrt));

        // A branch compares in ID, so anything still being computed in EX, or
        // a load still in MEM, cannot be forwarded in time.
        branch_stall = is_branch && ((EXRegWrite && ex_match) || (MEMMemRead && mem_match));

        stall = load_use || branch_stall;
    end

    // MEM forwarding for the branch compare wins over the register file and
    // its WB bypass, since MEM holds the younger value.
    always_comb begin
        cmp_a = rd1;
        cmp_b = rd2;
        if (MEMRegWrite && MEMWriteReg != 5'd0 && MEMWriteReg == IDrs) begin
            cmp_a = MEMALUResult;
        end
        if (MEMRegWrite && MEMWriteReg != 5'd0 && MEMWriteReg == IDrt) begin
            cmp_b = MEMALUResult;
        end
        taken = !stall && ((is_beq && cmp_a == cmp_b) || (is_bne && cmp_a != cmp_b));
        jump  = !stall && is_j;
    end

    always_comb begin
        if (Reset) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            IFFlush   = 1'b1;
            PCSrc     = PCSRC_PC4;
            ctrl_out  = '0;
        end else begin
            PCWrite   = !stall;
            IFIDWrite = !stall;
            IDEXFlush = stall;
            IFFlush   = taken || jump;
            PCSrc     = taken ? PCSRC_BRANCH : (jump ? PCSRC_JUMP : PCSRC_PC4);
            // Control is passed through unmasked; ID/EX applies the bubble.
            ctrl_out  = ctrl;
        end
    end

    assign IDRegWrite = ctrl_out.reg_write;
    assign IDMemtoReg = ctrl_out.mem_to_reg;
    assign IDMemWrite = ctrl_out.mem_write;
    assign IDMemRead  = ctrl_out.mem_read;
    assign IDRegDst   = ctrl_out.reg_dst;
    assign IDALUSrc   = ctrl_out.alu_src;
    assign IDALUOp    = ctrl_out.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage. Expected values are pushed onto exp_q when stimulus is
// driven and popped at the following negedge, where outputs are sampled.
// hz_obs   = {PCWrite, IFIDWrite, IDEXFlush, IFFlush, PCSrc}
// ctrl_obs = {RegWrite, MemtoReg, MemWrite, MemRead, RegDst, ALUSrc, ALUOp}
module tb_id_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr;
    logic [31:0] PCPlus4;
    logic        WBRegWrite;
    logic [4:0]  WBWriteReg;
    logic [31:0] WBWriteData;
    logic        EXRegWrite, EXMemRead;
    logic [4:0]  EXWriteReg;
    logic        MEMRegWrite, MEMMemRead;
    logic [4:0]  MEMWriteReg;
    logic [31:0] MEMALUResult;
    logic        IDRegWrite, IDMemtoReg, IDMemWrite, IDMemRead, IDRegDst, IDALUSrc;
    logic [1:0]  IDALUOp;
    logic [31:0] IDRegData1, IDRegData2, IDSignExImm;
    logic [4:0]  IDrs, IDrt, IDrd;
    logic        PCWrite, IFIDWrite, IDEXFlush, IFFlush;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget, JumpTarget;

    logic [5:0]  hz_obs;
    logic [7:0]  ctrl_obs;
    assign hz_obs   = {PCWrite, IFIDWrite, IDEXFlush, IFFlush, PCSrc};
    assign ctrl_obs = {IDRegWrite, IDMemtoReg, IDMemWrite, IDMemRead, IDRegDst, IDALUSrc, IDALUOp};

    localparam logic [5:0] HZ_RESET = 6'b001100;
    localparam logic [5:0] HZ_RUN   = 6'b110000;
    localparam logic [5:0] HZ_STALL = 6'b001000;
    localparam logic [5:0] HZ_TAKEN = 6'b110101;
    localparam logic [5:0] HZ_JUMP  = 6'b110110;

    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [31:0] model [32];
    int total = 0;
    int bad   = 0;

    id_stage dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .PCPlus4(PCPlus4),
        .WBRegWrite(WBRegWrite), .WBWriteReg(WBWriteReg), .WBWriteData(WBWriteData),
        .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead), .EXWriteReg(EXWriteReg),
        .MEMRegWrite(MEMRegWrite), .MEMMemRead(MEMMemRead), .MEMWriteReg(MEMWriteReg),
        .MEMALUResult(MEMALUResult),
        .IDRegWrite(IDRegWrite), .IDMemtoReg(IDMemtoReg), .IDMemWrite(IDMemWrite),
        .IDMemRead(IDMemRead), .IDRegDst(IDRegDst), .IDALUSrc(IDALUSrc), .IDALUOp(IDALUOp),
        .IDRegData1(IDRegData1), .IDRegData2(IDRegData2), .IDSignExImm(IDSignExImm),
        .IDrs(IDrs), .IDrt(IDrt), .IDrd(IDrd),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXFlush(IDEXFlush), .IFFlush(IFFlush),
        .PCSrc(PCSrc), .BranchTarget(BranchTarget), .JumpTarget(JumpTarget)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Instr = 32'd0; PCPlus4 = 32'd0;
        WBRegWrite = 1'b0; WBWriteReg = 5'd0; WBWriteData = 32'd0;
        EXRegWrite = 1'b0; EXMemRead = 1'b0; EXWriteReg = 5'd0;
        MEMRegWrite = 1'b0; MEMMemRead = 1'b0; MEMWriteReg = 5'd0; MEMALUResult = 32'd0;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        WBRegWrite = 1'b1; WBWriteReg = r; WBWriteData = d;
        if (r != 5'd0) model[r] = d;
        step();
        WBRegWrite = 1'b0; WBWriteReg = 5'd0; WBWriteData = 32'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1;
        clear_inputs();
        Instr = enc_r(5'd5, 5'd0, 5'd1, 6'b100000);
        WBRegWrite = 1'b1; WBWriteReg = 5'd5; WBWriteData = 32'hA5A5A5A5;
        #2;
        exp_q.push_back({26'd0, HZ_RESET});
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL reset_hz got=%b exp=%b", hz_obs, e[5:0]); end
        e = exp_q.pop_front(); total++;
        if (ctrl_obs !== e[7:0]) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl_obs, e[7:0]); end
        e = exp_q.pop_front(); total++;
        if (IDRegData1 !== e) begin bad++; $display("FAIL reset_wb_dropped got=%h exp=%h", IDRegData1, e); end
        step();
        WBRegWrite = 1'b0;
        step();
        Reset = 1'b0;
        exp_q.push_back({26'd0, HZ_RUN});
        exp_q.push_back(32'd0);
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL release_hz got=%b exp=%b", hz_obs, e[5:0]); end
        e = exp_q.pop_front(); total++;
        if (IDRegData1 !== e) begin bad++; $display("FAIL release_r5 got=%h exp=%h", IDRegData1, e); end
        step();
    endtask

    task automatic test_bypass();
        Instr = enc_r(5'd5, 5'd0, 5'd1, 6'b100000);
        WBRegWrite = 1'b1; WBWriteReg = 5'd5; WBWriteData = 32'h12345678;
        model[5] = 32'h12345678;
        exp_q.push_back(32'h12345678);
        exp_q.push_back({24'd0, 8'b1000_1010});
        exp_q.push_back({17'd0, 5'd5, 5'd0, 5'd1});
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (IDRegData1 !== e) begin bad++; $display("FAIL bypass_r5 got=%h exp=%h", IDRegData1, e); end
        e = exp_q.pop_front(); total++;
        if (ctrl_obs !== e[7:0]) begin bad++; $display("FAIL add_ctrl got=%b exp=%b", ctrl_obs, e[7:0]); end
        e = exp_q.pop_front(); total++;
        if ({IDrs, IDrt, IDrd} !== e[14:0]) begin bad++; $display("FAIL add_fields got=%h exp=%h", {IDrs, IDrt, IDrd}, e[14:0]); end
        step();
        WBRegWrite = 1'b0;
        exp_q.push_back(32'h12345678);
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (IDRegData1 !== e) begin bad++; $display("FAIL stored_r5 got=%h exp=%h", IDRegData1, e); end
        step();
        // write to $0 must be invisible both through the bypass and afterwards
        Instr = enc_r(5'd0, 5'd5, 5'd1, 6'b100000);
        WBRegWrite = 1'b1; WBWriteReg = 5'd0; WBWriteData = 32'hDEADBEEF;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h12345678);
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (IDRegData1 !== e) begin bad++; $display("FAIL r0_bypass got=%h exp=%h", IDRegData1, e); end
        e = exp_q.pop_front(); total++;
        if (IDRegData2 !== e) begin bad++; $display("FAIL r0_rt_r5 got=%h exp=%h", IDRegData2, e); end
        step();
        WBRegWrite = 1'b0;
        exp_q.push_back(32'd0);
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (IDRegData1 !== e) begin bad++; $display("FAIL r0_after got=%h exp=%h", IDRegData1, e); end
        step();
    endtask

    task automatic test_decode();
        logic [31:0] instrs [9];
        logic [7:0]  ctrls  [9];
        instrs[0] = enc_i(6'b100011, 5'd4, 5'd6, 16'h0010); ctrls[0] = 8'b1101_0100; // lw
        instrs[1] = enc_i(6'b101011, 5'd4, 5'd6, 16'h0010); ctrls[1] = 8'b0010_0100; // sw
        instrs[2] = enc_i(6'b001000, 5'd4, 5'd6, 16'h0001); ctrls[2] = 8'b1000_0100; // addi
        instrs[3] = enc_i(6'b001100, 5'd4, 5'd6, 16'h00FF); ctrls[3] = 8'b1000_0111; // andi
        instrs[4] = enc_i(6'b000100, 5'd4, 5'd6, 16'h0003); ctrls[4] = 8'b0000_0001; // beq
        instrs[5] = enc_i(6'b000101, 5'd4, 5'd6, 16'h0003); ctrls[5] = 8'b0000_0001; // bne
        instrs[6] = {6'b000010, 26'h0000100};               ctrls[6] = 8'b0000_0000; // j
        instrs[7] = enc_i(6'b111111, 5'd4, 5'd6, 16'h1234); ctrls[7] = 8'b0000_0000; // unsupported
        instrs[8] = enc_r(5'd4, 5'd6, 5'd7, 6'b101010);     ctrls[8] = 8'b1000_1010; // slt
        for (int i = 0; i < 9; i++) begin
            Instr = instrs[i];
            exp_q.push_back({24'd0, ctrls[i]});
            @(negedge Clk);
            e = exp_q.pop_front(); total++;
            if (ctrl_obs !== e[7:0]) begin bad++; $display("FAIL decode_%0d got=%b exp=%b", i, ctrl_obs, e[7:0]); end
            step();
        end
    endtask

    task automatic test_load_use();
        logic [31:0] instrs [6];
        logic        mrd    [6];
        logic        rw     [6];
        logic [4:0]  wr     [6];
        logic [5:0]  hz     [6];
        instrs[0] = enc_r(5'd2, 5'd4, 5'd3, 6'b100000);     mrd[0] = 1; rw[0] = 1; wr[0] = 2; hz[0] = HZ_STALL; // rs match
        instrs[1] = enc_r(5'd2, 5'd4, 5'd3, 6'b100000);     mrd[1] = 0; rw[1] = 0; wr[1] = 0; hz[1] = HZ_RUN;   // bubble in EX
        instrs[2] = enc_r(5'd4, 5'd2, 5'd3, 6'b100000);     mrd[2] = 1; rw[2] = 1; wr[2] = 2; hz[2] = HZ_STALL; // rt match R
        instrs[3] = enc_i(6'b001000, 5'd4, 5'd2, 16'h0001); mrd[3] = 1; rw[3] = 1; wr[3] = 2; hz[3] = HZ_RUN;   // addi rt is dest
        instrs[4] = enc_r(5'd0, 5'd0, 5'd3, 6'b100000);     mrd[4] = 1; rw[4] = 1; wr[4] = 0; hz[4] = HZ_RUN;   // $0 never stalls
        instrs[5] = enc_i(6'b101011, 5'd4, 5'd2, 16'h0000); mrd[5] = 1; rw[5] = 1; wr[5] = 2; hz[5] = HZ_STALL; // sw data reg
        for (int i = 0; i < 6; i++) begin
            Instr = instrs[i]; EXMemRead = mrd[i]; EXRegWrite = rw[i]; EXWriteReg = wr[i];
            exp_q.push_back({26'd0, hz[i]});
            @(negedge Clk);
            e = exp_q.pop_front(); total++;
            if (hz_obs !== e[5:0]) begin bad++; $display("FAIL load_use_%0d got=%b exp=%b", i, hz_obs, e[5:0]); end
            step();
        end
        // stalled decode still presents unmasked control
        Instr = enc_r(5'd2, 5'd4, 5'd3, 6'b100000); EXMemRead = 1'b1; EXRegWrite = 1'b1; EXWriteReg = 5'd2;
        exp_q.push_back({24'd0, 8'b1000_1010});
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (ctrl_obs !== e[7:0]) begin bad++; $display("FAIL stall_ctrl got=%b exp=%b", ctrl_obs, e[7:0]); end
        step();
        clear_inputs();
    endtask

    task automatic test_branch();
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        Instr = enc_i(6'b000100, 5'd1, 5'd2, 16'hFFFF); PCPlus4 = 32'h100;
        exp_q.push_back({26'd0, HZ_TAKEN});
        exp_q.push_back(32'h000000FC);
        exp_q.push_back(32'hFFFFFFFF);
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL beq_taken got=%b exp=%b", hz_obs, e[5:0]); end
        e = exp_q.pop_front(); total++;
        if (BranchTarget !== e) begin bad++; $display("FAIL beq_target got=%h exp=%h", BranchTarget, e); end
        e = exp_q.pop_front(); total++;
        if (IDSignExImm !== e) begin bad++; $display("FAIL sign_ext got=%h exp=%h", IDSignExImm, e); end
        step();
        Instr = enc_i(6'b000101, 5'd1, 5'd2, 16'h0004); PCPlus4 = 32'h200;
        exp_q.push_back({26'd0, HZ_RUN});
        exp_q.push_back(32'h00000210);
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL bne_not_taken got=%b exp=%b", hz_obs, e[5:0]); end
        e = exp_q.pop_front(); total++;
        if (BranchTarget !== e) begin bad++; $display("FAIL fwd_target got=%h exp=%h", BranchTarget, e); end
        step();
        // stall overrides a taken branch
        Instr = enc_i(6'b000100, 5'd1, 5'd2, 16'hFFFF); EXMemRead = 1'b1; EXRegWrite = 1'b1; EXWriteReg = 5'd1;
        exp_q.push_back({26'd0, HZ_STALL});
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL beq_stalled got=%b exp=%b", hz_obs, e[5:0]); end
        step();
        // EX writing $0 is not a hazard for bne $0,$2
        Instr = enc_i(6'b000101, 5'd0, 5'd2, 16'h0001); EXMemRead = 1'b0; EXRegWrite = 1'b1; EXWriteReg = 5'd0;
        exp_q.push_back({26'd0, HZ_TAKEN});
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL bne_r0_taken got=%b exp=%b", hz_obs, e[5:0]); end
        step();
        clear_inputs();
    endtask

    task automatic test_branch_fwd();
        wb_write(5'd2, 32'd9);
        Instr = enc_i(6'b000101, 5'd1, 5'd2, 16'h0002);
        exp_q.push_back({26'd0, HZ_TAKEN});
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL bne_plain got=%b exp=%b", hz_obs, e[5:0]); end
        step();
        // MEM forward of 9 into rs beats the concurrent WB bypass of 7
        MEMRegWrite = 1'b1; MEMWriteReg = 5'd1; MEMALUResult = 32'd9;
        WBRegWrite = 1'b1; WBWriteReg = 5'd1; WBWriteData = 32'd7;
        exp_q.push_back({26'd0, HZ_RUN});
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL bne_mem_fwd got=%b exp=%b", hz_obs, e[5:0]); end
        step();
        WBRegWrite = 1'b0;
        EXRegWrite = 1'b1; EXWriteReg = 5'd1;
        exp_q.push_back({26'd0, HZ_STALL});
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL bne_ex_stall got=%b exp=%b", hz_obs, e[5:0]); end
        step();
        clear_inputs();
        Instr = enc_i(6'b000101, 5'd1, 5'd2, 16'h0002);
        MEMMemRead = 1'b1; MEMRegWrite = 1'b1; MEMWriteReg = 5'd2;
        exp_q.push_back({26'd0, HZ_STALL});
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL bne_mem_load_stall got=%b exp=%b", hz_obs, e[5:0]); end
        step();
        // forward into rt: $1=7, MEM supplies 7 for $2 -> beq taken
        clear_inputs();
        Instr = enc_i(6'b000100, 5'd1, 5'd2, 16'h0002);
        MEMRegWrite = 1'b1; MEMWriteReg = 5'd2; MEMALUResult = 32'd7;
        exp_q.push_back({26'd0, HZ_TAKEN});
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL beq_rt_fwd got=%b exp=%b", hz_obs, e[5:0]); end
        step();
        clear_inputs();
    endtask

    task automatic test_jump();
        Instr = {6'b000010, 26'h0000040}; PCPlus4 = 32'h80000004;
        exp_q.push_back({26'd0, HZ_JUMP});
        exp_q.push_back(32'h80000100);
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL jump_hz got=%b exp=%b", hz_obs, e[5:0]); end
        e = exp_q.pop_front(); total++;
        if (JumpTarget !== e) begin bad++; $display("FAIL jump_target got=%h exp=%h", JumpTarget, e); end
        step();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        // consecutive writes; each is read through the bypass in its own cycle
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            Instr = enc_r(5'(8 + i), 5'(8 + i), 5'd1, 6'b100000);
            WBRegWrite = 1'b1; WBWriteReg = 5'(8 + i); WBWriteData = d;
            model[8 + i] = d;
            exp_q.push_back(d);
            @(negedge Clk);
            e = exp_q.pop_front(); total++;
            if (IDRegData1 !== e) begin bad++; $display("FAIL b2b_bypass_%0d got=%h exp=%h", i, IDRegData1, e); end
            step();
        end
        WBRegWrite = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int a = $urandom_range(8, 15);
            int b = $urandom_range(0, 15);
            Instr = enc_r(5'(a), 5'(b), 5'd1, 6'b100000);
            exp_q.push_back(model[a]);
            exp_q.push_back(b == 0 ? 32'd0 : model[b]);
            @(negedge Clk);
            e = exp_q.pop_front(); total++;
            if (IDRegData1 !== e) begin bad++; $display("FAIL b2b_rs_%0d got=%h exp=%h", i, IDRegData1, e); end
            e = exp_q.pop_front(); total++;
            if (IDRegData2 !== e) begin bad++; $display("FAIL b2b_rt_%0d got=%h exp=%h", i, IDRegData2, e); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        wb_write(5'd7, 32'd5);
        Instr = enc_r(5'd7, 5'd0, 5'd1, 6'b100000);
        exp_q.push_back(32'd5);
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (IDRegData1 !== e) begin bad++; $display("FAIL mid_r7_before got=%h exp=%h", IDRegData1, e); end
        #2;
        Reset = 1'b1;
        for (int r = 1; r < 32; r++) model[r] = 32'd0;
        #1;
        exp_q.push_back(32'd0);
        exp_q.push_back({26'd0, HZ_RESET});
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); total++;
        if (IDRegData1 !== e) begin bad++; $display("FAIL mid_r7_async got=%h exp=%h", IDRegData1, e); end
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL mid_hz got=%b exp=%b", hz_obs, e[5:0]); end
        e = exp_q.pop_front(); total++;
        if (ctrl_obs !== e[7:0]) begin bad++; $display("FAIL mid_ctrl got=%b exp=%b", ctrl_obs, e[7:0]); end
        // a write-back arriving while reset is held is dropped
        WBRegWrite = 1'b1; WBWriteReg = 5'd7; WBWriteData = 32'h55;
        step();
        WBRegWrite = 1'b0;
        Reset = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back({26'd0, HZ_RUN});
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (IDRegData1 !== e) begin bad++; $display("FAIL mid_r7_after got=%h exp=%h", IDRegData1, e); end
        e = exp_q.pop_front(); total++;
        if (hz_obs !== e[5:0]) begin bad++; $display("FAIL mid_release_hz got=%b exp=%b", hz_obs, e[5:0]); end
        step();
        Instr = enc_r(5'd10, 5'd5, 5'd1, 6'b100000);
        exp_q.push_back(model[10]);
        exp_q.push_back(model[5]);
        @(negedge Clk);
        e = exp_q.pop_front(); total++;
        if (IDRegData1 !== e) begin bad++; $display("FAIL mid_r10_cleared got=%h exp=%h", IDRegData1, e); end
        e = exp_q.pop_front(); total++;
        if (IDRegData2 !== e) begin bad++; $display("FAIL mid_r5_cleared got=%h exp=%h", IDRegData2, e); end
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int r = 0; r < 32; r++) model[r] = 32'd0;
        test_reset();
        test_bypass();
        test_decode();
        test_load_use();
        test_branch();
        test_branch_fwd();
        test_jump();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
